atan2_fp: RTL and testbench
===========================

ATAN2_FP -- requirements
Module: atan2_fp

Interface
REQ-001 SHALL have parameter ITERS, default 24, giving the CORDIC iteration count (legal range 8..28).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new conversion.
REQ-005 SHALL have port opy, input, 32 bits: IEEE-754 single-precision y (sine side).
REQ-006 SHALL have port opx, input, 32 bits: IEEE-754 single-precision x (cosine side).
REQ-007 SHALL have port angle_result, output, 32 bits: atan2(y,x) in radians, single precision, range [-pi, pi].
REQ-008 SHALL have port magnitude_result, output, 32 bits: sqrt(x^2+y^2), single precision (see Configuration).
REQ-009 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-010 SHALL have port done, output, 1 bit: high while results are valid.

Function
REQ-011 SHALL implement FSM states IDLE, ALIGN, ITER, PACK and DONE.
REQ-012 start SHALL be accepted in IDLE or DONE: opx and opy are captured, done clears, busy sets and the FSM moves to ALIGN; start in any other state SHALL be ignored.
REQ-013 ALIGN SHALL unpack both mantissas as {1,frac}, shift the smaller-exponent mantissa right by the exponent difference (a difference of 26 or more gives 0), and load 28-bit two's-complement x and y registers.
REQ-014 ALIGN quadrant pre-rotation, with z a 32-bit signed Q3.29 angle:
- x>=0: z=0.
- x<0, y>=0: (x,y) becomes (y,-x), z=+pi/2.
- x<0, y<0: (x,y) becomes (-y,x), z=-pi/2.
REQ-015 ITER SHALL perform one vectoring step per cycle for i=0..ITERS-1:
- if y>=0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i).
- otherwise: the opposite signs.
- Shifts SHALL use pre-update values.
- The step SHALL move to PACK after iteration ITERS-1.
REQ-016 The atan(2^-i) table SHALL be an ITERS-entry Q3.29 constant ROM, rounded to nearest.
REQ-017 PACK SHALL normalise |z| with a leading-one search, truncate to 23 fraction bits, set the sign from z, produce +0 for z==0, register angle_result, then enter DONE.
REQ-018 Latency: with start sampled at edge k, done SHALL be high after edge k+ITERS+2.
REQ-019 DONE SHALL hold the results and done=1 until the next accepted start.
REQ-020 Special cases SHALL be resolved in ALIGN, skip ITER and go to PACK with the constant result:
- exponent 0 is treated as zero; denormals are flushed.
- x=0 and y=0: +0 (0x00000000).
- y=0, x>0: 0x00000000.
- y=0, x<0: pi (0x40490FDB).
- x=0: +pi/2 (0x3FC90FDB) or -pi/2 (0xBFC90FDB) by the sign of y.
- either exponent 255: 0x7FC00000.
REQ-021 A special-case result SHALL assert done after edge k+3.
REQ-022 An ordinary angle_result SHALL be within 4 ulp of the true atan2 for ITERS=24.

Reset
REQ-023 n_rst low SHALL immediately force the FSM to IDLE and clear busy=0, done=0, angle_result=0, magnitude_result=0 and all datapath registers.
REQ-024 Reset asserted mid-conversion SHALL discard the operation; after release, no done SHALL appear without a new start.

Configuration
REQ-025 With macro ATAN2_MAGNITUDE_EN defined, PACK SHALL:
- multiply the final x by K = 0.60725293 (Q1.23 constant);
- restore the common exponent;
- register magnitude_result in the same cycle as angle_result, with no extra latency.
REQ-026 With ATAN2_MAGNITUDE_EN defined, the special cases SHALL give:
- |nonzero operand| as magnitude_result;
- 0 for the zero/zero case;
- 0x7FC00000 for inf/NaN.
REQ-027 Without ATAN2_MAGNITUDE_EN, magnitude_result SHALL be tied to 0 and no multiplier SHALL be synthesised.

Verification
REQ-028 Ordinary angle: opx=0x3F800000 (1.0), opy=0x3F800000 (1.0), start -> done after edge k+26, angle_result within 4 ulp of 0x3F490FDB; with the macro, magnitude_result within 4 ulp of 0x3FB504F3.
REQ-029 Third quadrant: opx=0xBF800000 (-1.0), opy=0xBF800000 (-1.0) -> angle_result within 4 ulp of 0xC016CBE4 (-3pi/4).
REQ-030 Special cases:
- opy=0, opx=-2.0 (0xC0000000) -> 0x40490FDB at edge k+3.
- opx=0, opy=0xBF000000 (-0.5) -> 0xBFC90FDB.
- opx=0x7F800000 -> 0x7FC00000.
REQ-031 Handshake: a start pulse in ITER is ignored (result unchanged, busy stays 1); a start in DONE restarts, clears done the next cycle and re-asserts done after ITERS+2 edges.
REQ-032 Reset mid-operation: n_rst low in ITER at iteration 10 -> outputs 0 at once; after release with no start for 40 cycles, done stays 0.

Source files
------------

// File: rtl/atan2_fp.sv
// Floating-point atan2(y, x) using a vectoring CORDIC on aligned fixed-point mantissas.
// Optional magnitude output when ATAN2_MAGNITUDE_EN is defined.
module atan2_fp #(
    parameter int ITERS = 24
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] opy,
    input  logic [31:0] opx,
    output logic [31:0] angle_result,
    output logic [31:0] magnitude_result,
    output logic        busy,
    output logic        done
);

    // Handshake: start is sampled on the rising edge and accepted only while busy is low
    // (IDLE or DONE); busy then stays high until done rises, and done holds until the next accepted start.
    typedef enum logic [2:0] {IDLE, ALIGN, ITER, PACK, DONE} state_t;

    localparam logic signed [31:0] PI_2   = 32'sh3243F6A9;
    localparam logic [31:0]        F_NAN  = 32'h7FC00000;
    localparam logic [31:0]        F_PI   = 32'h40490FDB;
    localparam logic [31:0]        F_PI2  = 32'h3FC90FDB;
    localparam logic [31:0]        F_NPI2 = 32'hBFC90FDB;

    state_t             state, state_nx;
    logic [31:0]        cap_x, cap_y;
    logic signed [27:0] xr, yr;
    logic signed [31:0] zr;
    logic [4:0]         iter;
    logic               special, settle;
    logic [31:0]        spec_ang;

    logic [7:0]         ex, ey, d;
    logic [27:0]        mx, my, ax, ay;
    logic signed [27:0] sx, sy, x_al, y_al, xs, ys;
    logic signed [31:0] z_al;
    logic               x_zero, y_zero, any_inf, is_spec;
    logic [31:0]        sp_ang, atan_v, az, az_sh, ang_bits;
    logic [5:0]         pa;

    function automatic logic [31:0] atan_rom(input logic [4:0] i);
        case (i)
            5'd0:    atan_rom = 32'h1921FB54;
            5'd1:    atan_rom = 32'h0ED63383;
            5'd2:    atan_rom = 32'h07D6DD7E;
            5'd3:    atan_rom = 32'h03FAB753;
            5'd4:    atan_rom = 32'h01FF55BB;
            5'd5:    atan_rom = 32'h00FFEAAE;
            5'd6:    atan_rom = 32'h007FFD55;
            5'd7:    atan_rom = 32'h003FFFAB;
            5'd8:    atan_rom = 32'h001FFFF5;
            5'd9:    atan_rom = 32'h000FFFFF;
            // beyond i=9 the cubic term is below half an LSB, so atan(2^-i) rounds to 2^-i
            default: atan_rom = (i <= 5'd27) ? (32'd1 << (5'd29 - i)) : 32'd0;
        endcase
    endfunction

    function automatic logic [5:0] lead_one(input logic [63:0] v);
        lead_one = 6'd0;
        for (int b = 0; b < 64; b++) begin
            if (v[b]) lead_one = 6'(b);
        end
    endfunction

    always_comb begin
        ex = cap_x[30:23];
        ey = cap_y[30:23];
        mx = {3'b0, 1'b1, cap_x[22:0], 1'b0};
        my = {3'b0, 1'b1, cap_y[22:0], 1'b0};
        if (ex >= ey) begin
            d  = ex - ey;
            ax = mx;
            ay = (d >= 8'd26) ? 28'd0 : (my >> d);
        end else begin
            d  = ey - ex;
            ay = my;
            ax = (d >= 8'd26) ? 28'd0 : (mx >> d);
        end
        sx = cap_x[31] ? -$signed(ax) : $signed(ax);
        sy = cap_y[31] ? -$signed(ay) : $signed(ay);
        // rotate left-half-plane vectors by -/+90 degrees so CORDIC always starts with x >= 0
        if (!cap_x[31]) begin
            x_al = sx;  y_al = sy;  z_al = 32'sd0;
        end else if (!cap_y[31]) begin
            x_al = sy;  y_al = -sx; z_al = PI_2;
        end else begin
            x_al = -sy; y_al = sx;  z_al = -PI_2;
        end
        x_zero  = (ex == 8'd0);
        y_zero  = (ey == 8'd0);
        any_inf = (ex == 8'hFF) || (ey == 8'hFF);
        is_spec = any_inf || x_zero || y_zero;
        if (any_inf)     sp_ang = F_NAN;
        else if (y_zero) sp_ang = (x_zero || !cap_x[31]) ? 32'd0 : F_PI;
        else if (x_zero) sp_ang = cap_y[31] ? F_NPI2 : F_PI2;
        else             sp_ang = 32'd0;
    end

    always_comb begin
        atan_v   = atan_rom(iter);
        xs       = xr >>> iter;
        ys       = yr >>> iter;
        az       = zr[31] ? $unsigned(-zr) : $unsigned(zr);
        pa       = lead_one({32'd0, az});
        az_sh    = az << (6'd31 - pa);
        ang_bits = (az == 32'd0) ? 32'd0 : {zr[31], 8'(pa) + 8'd98, 23'(az_sh >> 8)};
    end

`ifdef ATAN2_MAGNITUDE_EN
    localparam logic [23:0] K_Q123 = 24'h4DBA77;
    logic [7:0]         emax, e_big;
    logic [31:0]        spec_mag, sp_mag, mag_bits;
    logic [50:0]        prod;
    logic [63:0]        mag_sh;
    logic [5:0]         pm;
    logic signed [10:0] me;

    always_comb begin
        e_big = (ex >= ey) ? ex : ey;
        if (any_inf)     sp_mag = F_NAN;
        else if (y_zero) sp_mag = x_zero ? 32'd0 : {1'b0, cap_x[30:0]};
        else             sp_mag = {1'b0, cap_y[30:0]};
        prod   = 51'(xr[26:0]) * 51'(K_Q123);
        pm     = lead_one({13'd0, prod});
        mag_sh = {13'd0, prod} << (6'd63 - pm);
        // x carries the larger mantissa at bit 24 and K is Q1.23, hence the fixed 47 offset
        me     = $signed({5'd0, pm}) + $signed({3'd0, emax}) - 11'sd47;
        if (prod == 51'd0 || me <= 11'sd0) mag_bits = 32'd0;
        else if (me >= 11'sd255)           mag_bits = 32'h7F800000;
        else                               mag_bits = {1'b0, me[7:0], 23'(mag_sh >> 40)};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            emax             <= 8'd0;
            spec_mag         <= 32'd0;
            magnitude_result <= 32'd0;
        end else if (state == ALIGN) begin
            emax     <= e_big;
            spec_mag <= sp_mag;
        end else if (state == PACK && (!special || settle)) begin
            magnitude_result <= special ? spec_mag : mag_bits;
        end
    end
`else
    assign magnitude_result = 32'd0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = ALIGN;
            ALIGN:      state_nx = is_spec ? PACK : ITER;
            ITER:       if (iter == 5'(ITERS - 1)) state_nx = PACK;
            // constant results spend one extra cycle here so their latency is a fixed three edges
            PACK:       if (!special || settle) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cap_x        <= 32'd0;
            cap_y        <= 32'd0;
            xr           <= 28'sd0;
            yr           <= 28'sd0;
            zr           <= 32'sd0;
            iter         <= 5'd0;
            special      <= 1'b0;
            settle       <= 1'b0;
            spec_ang     <= 32'd0;
            angle_result <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cap_x <= opx;
                        cap_y <= opy;
                    end
                end
                ALIGN: begin
                    xr       <= x_al;
                    yr       <= y_al;
                    zr       <= z_al;
                    iter     <= 5'd0;
                    special  <= is_spec;
                    settle   <= 1'b0;
                    spec_ang <= sp_ang;
                end
                ITER: begin
                    if (!yr[27]) begin
                        xr <= xr + ys;
                        yr <= yr - xs;
                        zr <= zr + $signed(atan_v);
                    end else begin
                        xr <= xr - ys;
                        yr <= yr + xs;
                        zr <= zr - $signed(atan_v);
                    end
                    iter <= iter + 5'd1;
                end
                PACK: begin
                    if (special && !settle) settle <= 1'b1;
                    else angle_result <= special ? spec_ang : ang_bits;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ALIGN) || (state == ITER) || (state == PACK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_atan2_fp.sv
// Self-checking bench for atan2_fp: directed and random operands against a real-arithmetic model.
module tb_atan2_fp;

    localparam int ITERS = 24;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] opy = 32'd0;
    logic [31:0] opx = 32'd0;
    logic [31:0] angle_result, magnitude_result;
    logic        busy, done;

    int n_checks = 0;
    int n_fail = 0;

    atan2_fp #(.ITERS(ITERS)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .opy(opy), .opx(opx),
        .angle_result(angle_result), .magnitude_result(magnitude_result),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol = 0);
        longint diff;
        n_checks++;
        diff = longint'({32'd0, obs}) - longint'({32'd0, exp});
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real r;
        if (b[30:23] == 8'd0) return 0.0;
        r = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real a;
        int  e, m;
        logic [7:0] eb;
        if (r == 0.0) return 32'd0;
        a = (r < 0.0) ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = $rtoi(a * 8388608.0 + 0.5);
        if (m >= 16777216) begin m = m / 2; e++; end
        eb = 8'(e + 127);
        return {(r < 0.0), eb, 23'(m)};
    endfunction

    // reference: special-case table first, otherwise true atan2 / hypot rounded to single
    task automatic model(input logic [31:0] y, input logic [31:0] x,
                         output logic sp, output logic [31:0] ang, output logic [31:0] mag);
        logic xz, yz;
        real  fx, fy;
        xz = (x[30:23] == 8'd0);
        yz = (y[30:23] == 8'd0);
        sp = 1'b1;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            ang = 32'h7FC00000; mag = 32'h7FC00000;
        end else if (xz && yz) begin
            ang = 32'd0; mag = 32'd0;
        end else if (yz) begin
            ang = x[31] ? 32'h40490FDB : 32'd0; mag = {1'b0, x[30:0]};
        end else if (xz) begin
            ang = y[31] ? 32'hBFC90FDB : 32'h3FC90FDB; mag = {1'b0, y[30:0]};
        end else begin
            sp  = 1'b0;
            fx  = f2r(x);
            fy  = f2r(y);
            ang = r2f($atan2(fy, fx));
            mag = r2f($sqrt(fx * fx + fy * fy));
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] y, input logic [31:0] x, input int glitch_at);
        logic        sp;
        logic [31:0] e_ang, e_mag;
        int          cnt;
        model(y, x, sp, e_ang, e_mag);
        opy = y; opx = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_dclr"}, {31'd0, done}, 32'd0);
        for (cnt = 1; cnt <= 100; cnt++) begin
            @(posedge clk); #1;
            if (start) begin start = 1'b0; opy = y; opx = x; end
            if (done) break;
            if (cnt == glitch_at) begin
                check({tag, "_gbusy"}, {31'd0, busy}, 32'd1);
                opy = 32'h40400000; opx = 32'hC0A00000; start = 1'b1;
            end
        end
        check({tag, "_lat"}, 32'(cnt), sp ? 32'd3 : 32'(ITERS + 2));
        check({tag, "_ang"}, angle_result, e_ang, sp ? 0 : 4);
`ifdef ATAN2_MAGNITUDE_EN
        check({tag, "_mag"}, magnitude_result, e_mag, sp ? 0 : 8);
`else
        check({tag, "_mag"}, magnitude_result, 32'd0);
`endif
        check({tag, "_bdone"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_normal();
        logic [7:0] e;
        e = 8'($urandom_range(110, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] rx, ry;
        int          seen;

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ang", angle_result, 32'd0);
        check("rst_mag", magnitude_result, 32'd0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        run_op("q1", 32'h3F800000, 32'h3F800000, 0);
        check("q1_const", angle_result, 32'h3F490FDB, 4);
`ifdef ATAN2_MAGNITUDE_EN
        check("q1_mconst", magnitude_result, 32'h3FB504F3, 4);
`endif
        run_op("q3", 32'hBF800000, 32'hBF800000, 0);
        check("q3_const", angle_result, 32'hC016CBE4, 4);
        run_op("sp_pi", 32'h00000000, 32'hC0000000, 0);
        run_op("sp_npi2", 32'hBF000000, 32'h00000000, 0);
        run_op("sp_nan", 32'h3F800000, 32'h7F800000, 0);
        run_op("sp_zz", 32'h80000000, 32'h00000000, 0);
        run_op("sp_ypos", 32'h00000000, 32'h40A00000, 0);
        run_op("glitch", 32'h3F000000, 32'hBFC00000, 5);

        for (int i = 0; i < 30; i++) begin
            ry = rand_normal();
            rx = rand_normal();
            if ($atan2(f2r(ry), f2r(rx)) < 1.0 && $atan2(f2r(ry), f2r(rx)) > -1.0) rx[31] = ~rx[31];
            run_op("rnd", ry, rx, 0);
        end

        for (int i = 0; i < 10; i++) begin
            ry = rand_normal();
            rx = rand_normal();
            case ($urandom_range(0, 4))
                0: rx[30:0] = 31'd0;
                1: ry[30:0] = 31'd0;
                2: begin rx[30:23] = 8'd0; ry[30:0] = 31'd0; end
                3: ry[30:23] = 8'hFF;
                default: rx[30:23] = 8'd0;
            endcase
            run_op("rsp", ry, rx, 0);
        end

        opy = 32'h3F800000; opx = 32'h3F000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_ang", angle_result, 32'd0);
        check("mrst_mag", magnitude_result, 32'd0);
        #20 n_rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("mrst_quiet", 32'(seen), 32'd0);

        run_op("after_rst", 32'hC0400000, 32'h3F800000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
